// File: rtl/cpu_pkg.sv
// Shared CPU pipeline definitions: forwarding-mux select encodings and
// the default register-address width.
package cpu_pkg;

   localparam int RA_W_DFLT = 5;

   typedef enum logic [1:0] {
      FWD_QA  = 2'b00,
      FWD_R   = 2'b01,
      FWD_MR  = 2'b10,
      FWD_MDO = 2'b11
   } fwd_e;

endpackage

// File: rtl/fwd_sel.sv
// Operand forwarding select for one source register: EX result wins over
// MEM, a load still in EX never forwards, and register 0 never matches.
module fwd_sel
   import cpu_pkg::*;
#(
   parameter int RA_W = RA_W_DFLT
) (
   input  logic [RA_W-1:0] rs,
   input  logic            used,
   input  logic [RA_W-1:0] ex_rd,
   input  logic            ex_wreg,
   input  logic            ex_m2reg,
   input  logic [RA_W-1:0] mem_rd,
   input  logic            mem_wreg,
   input  logic            mem_m2reg,
   output logic [1:0]      sel
);

   always_comb begin
      sel = FWD_QA;
      if (used && (rs != '0)) begin
         if (ex_wreg && (ex_rd == rs) && !ex_m2reg)
            sel = FWD_R;
         else if (mem_wreg && (mem_rd == rs))
            sel = mem_m2reg ? FWD_MDO : FWD_MR;
      end
   end

endmodule

// File: rtl/fwd_hazard_ctrl.sv
// Forwarding/hazard control for the ID stage: shadows EX/MEM destination
// info, stalls on load-use and holds EX while a multicycle multiply runs.
module fwd_hazard_ctrl
   import cpu_pkg::*;
#(
   parameter int unsigned MUL_LAT = 4,
   parameter int          RA_W    = RA_W_DFLT
) (
   input  logic            clk,
   input  logic            clrn,
   input  logic [RA_W-1:0] id_rs,
   input  logic [RA_W-1:0] id_rt,
   input  logic            id_use_rs,
   input  logic            id_use_rt,
   input  logic [RA_W-1:0] id_rd,
   input  logic            id_wreg,
   input  logic            id_m2reg,
   input  logic            id_mul,
   output logic [1:0]      fwda,
   output logic [1:0]      fwdb,
   output logic            wpcir,
   output logic            bubble,
   output logic            ex_hold
);

   logic [RA_W-1:0] ex_rd, mem_rd;
   logic            ex_wreg, ex_m2reg, ex_mul;
   logic            mem_wreg, mem_m2reg;
   logic [3:0]      mul_cnt;
   logic            mul_busy, ld_use;

   fwd_sel #(.RA_W(RA_W)) u_sel_a (
      .rs(id_rs), .used(id_use_rs),
      .ex_rd(ex_rd), .ex_wreg(ex_wreg), .ex_m2reg(ex_m2reg),
      .mem_rd(mem_rd), .mem_wreg(mem_wreg), .mem_m2reg(mem_m2reg),
      .sel(fwda)
   );

   fwd_sel #(.RA_W(RA_W)) u_sel_b (
      .rs(id_rt), .used(id_use_rt),
      .ex_rd(ex_rd), .ex_wreg(ex_wreg), .ex_m2reg(ex_m2reg),
      .mem_rd(mem_rd), .mem_wreg(mem_wreg), .mem_m2reg(mem_m2reg),
      .sel(fwdb)
   );

   // mul_cnt is only ever nonzero with a multiply in EX; ex_mul makes that explicit
   assign mul_busy = ex_mul && (mul_cnt != '0);

   always_comb begin
      ld_use = 1'b0;
      if (ex_wreg && ex_m2reg && (ex_rd != '0))
         ld_use = (id_use_rs && (ex_rd == id_rs)) ||
                  (id_use_rt && (ex_rd == id_rt));
   end

   assign ex_hold = mul_busy;
   assign bubble  = ld_use && !mul_busy;
   assign wpcir   = !(mul_busy || ld_use);

   always_ff @(posedge clk) begin
      if (!clrn) begin
         ex_rd     <= '0;
         ex_wreg   <= 1'b0;
         ex_m2reg  <= 1'b0;
         ex_mul    <= 1'b0;
         mem_rd    <= '0;
         mem_wreg  <= 1'b0;
         mem_m2reg <= 1'b0;
         mul_cnt   <= '0;
      end else if (mul_busy) begin
         mem_wreg  <= 1'b0;
         mem_m2reg <= 1'b0;
         mul_cnt   <= mul_cnt - 4'd1;
      end else begin
         mem_rd    <= ex_rd;
         mem_wreg  <= ex_wreg;
         mem_m2reg <= ex_m2reg;
         if (ld_use) begin
            ex_rd    <= '0;
            ex_wreg  <= 1'b0;
            ex_m2reg <= 1'b0;
            ex_mul   <= 1'b0;
            mul_cnt  <= '0;
         end else begin
            ex_rd    <= id_rd;
            ex_wreg  <= id_wreg;
            ex_m2reg <= id_m2reg;
            ex_mul   <= id_mul;
            mul_cnt  <= id_mul ? 4'(MUL_LAT - 1) : '0;
         end
      end
   end

endmodule
